qspi_collector_rr: RTL and testbench
====================================

Name: qspi_collector_rr

Overview:
- Parametrised successor of the pipeline's collector stage.
- Gathers finished words from NUM_CH encrypter channels in strict round-robin order and serialises each word onto a LANES-wide QSPI-style output with ready backpressure.
- Adds a runtime channel-enable mask, selectable bit order, back-to-back word streaming and a words-sent counter.
- Sits between the encrypter array and the top-level QSPI output.

Parameters:
- NUM_CH, 2: number of encrypter channels (1..16).
- WORD_W, 32: encrypter word width; must be a multiple of LANES.
- LANES, 4: output lanes per beat (1, 2, 4 or 8). BEATS = WORD_W/LANES.
- MSB_FIRST, 1: 1 = most-significant lane group sent first; 0 = least-significant first.

Ports:
- clk  in  1  sole clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- enc_data  in  NUM_CH*WORD_W  channel c word at bits [c*WORD_W +: WORD_W].
- enc_data_ready  in  NUM_CH  channel c holds a valid word.
- enc_capture  out  NUM_CH  one-cycle pulse: channel c's word has been taken.
- active_mask  in  NUM_CH  channels included in the rotation.
- qspi_data  out  LANES  current beat.
- qspi_sending  out  1  qspi_data is valid.
- qspi_ready  in  1  downstream accepts a beat this cycle.
- words_sent  out  32  count of fully transmitted words.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - qspi_data=0, qspi_sending=0, enc_capture=0, words_sent=0.
  - Shift register=0, ptr=0, beat_cnt=0, state=WAIT.
- Reset asserted mid-word aborts the word. No capture pulse is emitted; the partial word is lost.
- Next-pointer function nxt(p): first channel after p, cyclically, with active_mask set. If p is the only active channel, nxt(p)=p.
- State WAIT:
  - If active_mask[ptr]=0: set ptr<=nxt(ptr) and stay in WAIT.
  - If active_mask is all zero: hold ptr and stay in WAIT. No capture.
  - Else if enc_data_ready[ptr]=1: load the shift register with that channel's word, set enc_capture[ptr]=1 for exactly the next cycle, set beat_cnt=0, go to SHIFT.
  - Else wait on the same ptr. Other channels' ready bits are ignored, so order is strict.
- State SHIFT:
  - qspi_sending=1. qspi_data = top LANES bits of the shift register (MSB_FIRST=1) or bottom LANES bits (MSB_FIRST=0).
  - A beat transfers on a rising edge with qspi_sending=1 and qspi_ready=1.
  - On a transfer, shift by LANES toward the sent end and increment beat_cnt.
  - qspi_ready=0 holds qspi_data and all state unchanged.
- Last beat transfer (beat_cnt=BEATS-1):
  - words_sent += 1, wrapping at 2^32.
  - ptr advances to p'=nxt(ptr).
  - If active_mask[p']=1 and enc_data_ready[p']=1 in the same cycle: load p' directly and stay in SHIFT. enc_capture[p'] pulses next cycle, and qspi_sending stays 1 with no gap.
  - Otherwise go to WAIT with qspi_sending=0 next cycle.
- active_mask is sampled only at pointer decisions. Clearing a channel mid-word does not abort the word in flight.
- Capture latency: word sampled on edge N; enc_capture high during cycle N+1. The first beat is visible on qspi_data during cycle N+1.
- Re-sampling guard: a channel whose enc_capture is high is treated as not ready that cycle. This covers NUM_CH=1 with BEATS=1.
- Output throughput: at most one beat per cycle; one word per BEATS cycles when streaming.
- enc_capture is never high on more than one bit at a time.

Test Plan:
- Defaults; ch0=0xB4352B93 ready, ch1=0x01234567 ready, qspi_ready=1 → nibbles B,4,3,5,2,B,9,3,0,1,2,3,4,5,6,7 on consecutive cycles, qspi_sending high for 16 cycles with no gap, enc_capture 01 then (8 cycles later) 10, words_sent=2.
- Strict order: only ch1 ready after reset → no output until ch0 ready. Then ch0's word goes first, then ch1's.
- Backpressure: qspi_ready low on alternate cycles during 0xB4352B93 → same nibble sequence, each held 2 cycles, 16 cycles total, no duplicated or dropped nibbles.
- Mask: NUM_CH=4, active_mask=0b1010, all channels ready → capture order 1,3,1,3. Then mask=0 → bench sees WAIT, qspi_sending=0, no capture.
- Width/order: LANES=1, WORD_W=8, MSB_FIRST=0, word 0xA5 → bits 1,0,1,0,0,1,0,1; LANES=8, WORD_W=16, word 0xBEEF → 0xBE, 0xEF.
- Reset mid-word: drop reset after 3 beats → all outputs 0 immediately. After release, the first word taken is ch0's and words_sent restarts at 0.

Source files
------------

// File: rtl/qspi_collector_rr.sv
// Round-robin collector: takes finished words from NUM_CH encrypter channels in strict
// pointer order and streams each one out LANES bits per beat with ready backpressure.
module qspi_collector_rr #(
    parameter int NUM_CH    = 2,
    parameter int WORD_W    = 32,
    parameter int LANES     = 4,
    parameter int MSB_FIRST = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_CH*WORD_W-1:0] enc_data,
    input  logic [NUM_CH-1:0]        enc_data_ready,
    output logic [NUM_CH-1:0]        enc_capture,
    input  logic [NUM_CH-1:0]        active_mask,
    output logic [LANES-1:0]         qspi_data,
    output logic                     qspi_sending,
    input  logic                     qspi_ready,
    output logic [31:0]              words_sent,
    output logic                     state_dbg
);

    localparam int BEATS = WORD_W / LANES;
    localparam int PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    typedef enum logic {
        S_WAIT  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;

    state_t             state;
    logic [PTR_W-1:0]   ptr;
    logic [CNT_W-1:0]   beat_cnt;
    logic [WORD_W-1:0]  shreg;

    logic [NUM_CH-1:0]  ready_eff;
    logic [PTR_W-1:0]   ptr_nxt;
    logic [WORD_W-1:0]  shreg_shifted;
    logic               at_last;

    // First channel after p (cyclically) with its mask bit set; p itself if none other.
    function automatic logic [PTR_W-1:0] nxt(input logic [PTR_W-1:0] p,
                                             input logic [NUM_CH-1:0] m);
        logic [PTR_W-1:0] r;
        logic             found;
        r     = p;
        found = 1'b0;
        for (int i = 1; i <= NUM_CH; i++) begin
            int idx;
            idx = (int'(p) + i) % NUM_CH;
            if (!found && m[idx]) begin
                r     = PTR_W'(idx);
                found = 1'b1;
            end
        end
        return r;
    endfunction

    function automatic logic [WORD_W-1:0] word_of(input logic [PTR_W-1:0] p);
        return enc_data[int'(p)*WORD_W +: WORD_W];
    endfunction

    // A channel whose capture pulse is still high is the word just taken, not a new one.
    assign ready_eff     = enc_data_ready & ~enc_capture;
    assign ptr_nxt       = nxt(ptr, active_mask);
    assign at_last       = (beat_cnt == CNT_W'(BEATS - 1));
    assign shreg_shifted = (MSB_FIRST != 0) ? (shreg << LANES) : (shreg >> LANES);

    // Handshake: qspi_data is valid while qspi_sending is high; a beat moves on a rising
    // edge where qspi_sending && qspi_ready, otherwise data and all state hold.
    generate
        if (MSB_FIRST != 0) begin : g_msb
            assign qspi_data = shreg[WORD_W-1 -: LANES];
        end else begin : g_lsb
            assign qspi_data = shreg[LANES-1:0];
        end
    endgenerate

    assign qspi_sending = (state == S_SHIFT);
    assign state_dbg    = state;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= S_WAIT;
            ptr         <= '0;
            beat_cnt    <= '0;
            shreg       <= '0;
            enc_capture <= '0;
            words_sent  <= '0;
        end else begin
            enc_capture <= '0;
            case (state)
                S_WAIT: begin
                    if (active_mask != '0) begin
                        if (!active_mask[ptr]) begin
                            ptr <= ptr_nxt;
                        end else if (ready_eff[ptr]) begin
                            shreg       <= word_of(ptr);
                            enc_capture <= NUM_CH'(1) << ptr;
                            beat_cnt    <= '0;
                            state       <= S_SHIFT;
                        end
                    end
                end
                S_SHIFT: begin
                    if (qspi_ready) begin
                        shreg <= shreg_shifted;
                        if (at_last) begin
                            words_sent <= words_sent + 32'd1;
                            ptr        <= ptr_nxt;
                            beat_cnt   <= '0;
                            // Stream the next word with no idle cycle when it is already waiting.
                            if (active_mask[ptr_nxt] && ready_eff[ptr_nxt]) begin
                                shreg       <= word_of(ptr_nxt);
                                enc_capture <= NUM_CH'(1) << ptr_nxt;
                            end else begin
                                state <= S_WAIT;
                            end
                        end else begin
                            beat_cnt <= beat_cnt + CNT_W'(1);
                        end
                    end
                end
                default: state <= S_WAIT;
            endcase
        end
    end

endmodule

// File: tb/tb_qspi_collector_rr.sv
// Bench for qspi_collector_rr: three configurations, directed steps plus a randomized
// two-channel run checked against a word-order and beat-split reference model.
module tb_qspi_collector_rr;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    int checks = 0;
    int errors = 0;

    // Default configuration
    logic [63:0] a_data;
    logic [1:0]  a_rdy, a_cap, a_mask;
    logic [3:0]  a_q;
    logic        a_send, a_qr, a_st;
    logic [31:0] a_ws;
    // Four channels, byte lanes, 16-bit words
    logic [63:0] b_data;
    logic [3:0]  b_rdy, b_cap, b_mask;
    logic [7:0]  b_q;
    logic        b_send, b_qr, b_st;
    logic [31:0] b_ws;
    // One channel, single lane, 8-bit words, LSB first
    logic [7:0]  c_data;
    logic [0:0]  c_rdy, c_cap, c_mask, c_q;
    logic        c_send, c_qr, c_st;
    logic [31:0] c_ws;

    qspi_collector_rr dut_a (
        .clk(clk), .reset(rst_n), .enc_data(a_data), .enc_data_ready(a_rdy),
        .enc_capture(a_cap), .active_mask(a_mask), .qspi_data(a_q), .qspi_sending(a_send),
        .qspi_ready(a_qr), .words_sent(a_ws), .state_dbg(a_st)
    );

    qspi_collector_rr #(.NUM_CH(4), .WORD_W(16), .LANES(8), .MSB_FIRST(1)) dut_b (
        .clk(clk), .reset(rst_n), .enc_data(b_data), .enc_data_ready(b_rdy),
        .enc_capture(b_cap), .active_mask(b_mask), .qspi_data(b_q), .qspi_sending(b_send),
        .qspi_ready(b_qr), .words_sent(b_ws), .state_dbg(b_st)
    );

    qspi_collector_rr #(.NUM_CH(1), .WORD_W(8), .LANES(1), .MSB_FIRST(0)) dut_c (
        .clk(clk), .reset(rst_n), .enc_data(c_data), .enc_data_ready(c_rdy),
        .enc_capture(c_cap), .active_mask(c_mask), .qspi_data(c_q), .qspi_sending(c_send),
        .qspi_ready(c_qr), .words_sent(c_ws), .state_dbg(c_st)
    );

    logic [7:0]  exp_q[$];
    logic [7:0]  got_q[$];
    logic [31:0] w0q[$];
    logic [31:0] w1q[$];
    int          cap_log[$];
    int          act[$];

    logic [3:0]  q_log[20];
    logic        s_log[20];
    logic [1:0]  c_log[20];
    logic [31:0] w0, w1, w, ws0;
    logic [15:0] w3;
    int          ncap, nsend, nwords, ch;
    logic        busy, found;
    logic [1:0]  first_cap;
    logic [31:0] first_ws;
    logic [3:0]  first_q;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Beat k of a word: lane group counted from the sent end.
    function automatic logic [7:0] beat_of(input logic [31:0] wd, input int k, input int ww,
                                           input int lanes, input bit msb);
        logic [31:0] v;
        if (msb) v = wd >> (ww - lanes * (k + 1));
        else     v = wd >> (lanes * k);
        return 8'(v & ((32'd1 << lanes) - 32'd1));
    endfunction

    function automatic void push_word(input logic [31:0] wd, input int ww, input int lanes,
                                      input bit msb, input int reps);
        for (int k = 0; k < ww / lanes; k++)
            for (int r = 0; r < reps; r++)
                exp_q.push_back(beat_of(wd, k, ww, lanes, msb));
    endfunction

    task automatic compare_queues(input string tag);
        check({tag, "_len"}, 64'(got_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            check(tag, 64'(got_q[i]), 64'(exp_q[i]));
    endtask

    initial begin
        rst_n = 1'b0;
        a_data = '0; a_rdy = '0; a_mask = 2'b11;   a_qr = 1'b0;
        b_data = '0; b_rdy = '0; b_mask = 4'b1010; b_qr = 1'b0;
        c_data = '0; c_rdy = '0; c_mask = 1'b1;    c_qr = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_qspi_data", 64'(a_q), 64'(0));
        check("rst_sending", 64'(a_send), 64'(0));
        check("rst_capture", 64'(a_cap), 64'(0));
        check("rst_words_sent", 64'(a_ws), 64'(0));
        check("rst_state", 64'(a_st), 64'(0));
        rst_n = 1'b1;
        tick();

        // Two ready words stream back to back, channel 0 first.
        a_data = {32'h01234567, 32'hB4352B93};
        a_rdy = 2'b11;
        a_qr = 1'b1;
        exp_q.delete();
        push_word(32'hB4352B93, 32, 4, 1'b1, 1);
        push_word(32'h01234567, 32, 4, 1'b1, 1);
        ncap = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            s_log[i] = a_send;
            q_log[i] = a_q;
            c_log[i] = a_cap;
            if (a_cap != 2'b00) begin
                ncap++;
                a_rdy = a_rdy & ~a_cap;
            end
        end
        for (int i = 0; i < 16; i++)
            check("t1_beat", 64'({s_log[i], q_log[i]}), 64'({1'b1, exp_q[i][3:0]}));
        check("t1_idle_after", 64'(s_log[16]), 64'(0));
        check("t1_cap_first", 64'(c_log[0]), 64'(2'b01));
        check("t1_cap_second", 64'(c_log[8]), 64'(2'b10));
        check("t1_cap_count", 64'(ncap), 64'(2));
        check("t1_words_sent", 64'(a_ws), 64'(2));

        // Strict order: channel 1 alone must not be taken while pointer sits on 0.
        w0 = $urandom;
        w1 = $urandom;
        a_data = {w1, w0};
        a_rdy = 2'b10;
        busy = 1'b0;
        repeat (10) begin
            tick();
            if (a_send || a_cap != 2'b00) busy = 1'b1;
        end
        check("t2_hold_off", 64'(busy), 64'(0));
        a_rdy = 2'b11;
        exp_q.delete(); got_q.delete(); cap_log.delete();
        push_word(w0, 32, 4, 1'b1, 1);
        push_word(w1, 32, 4, 1'b1, 1);
        for (int i = 0; i < 30; i++) begin
            tick();
            if (a_cap != 2'b00) begin
                cap_log.push_back($clog2(a_cap));
                a_rdy = a_rdy & ~a_cap;
            end
            if (a_send && a_qr) got_q.push_back(8'(a_q));
        end
        check("t2_cap_count", 64'(cap_log.size()), 64'(2));
        if (cap_log.size() == 2) begin
            check("t2_cap_order0", 64'(cap_log[0]), 64'(0));
            check("t2_cap_order1", 64'(cap_log[1]), 64'(1));
        end
        compare_queues("t2_beat");
        check("t2_words_sent", 64'(a_ws), 64'(4));

        // Backpressure on alternate cycles: every nibble held exactly two cycles.
        a_data[31:0] = 32'hB4352B93;
        a_rdy = 2'b01;
        a_qr = 1'b0;
        nsend = 0;
        exp_q.delete(); got_q.delete();
        push_word(32'hB4352B93, 32, 4, 1'b1, 2);
        for (int i = 0; i < 40; i++) begin
            tick();
            if (a_cap != 2'b00) a_rdy = a_rdy & ~a_cap;
            if (a_send) begin
                got_q.push_back(8'(a_q));
                a_qr = (nsend % 2 == 1);
                nsend++;
            end else begin
                a_qr = 1'b0;
            end
        end
        check("t3_send_cycles", 64'(nsend), 64'(16));
        compare_queues("t3_beat");

        // Randomized: channels offer words at random, downstream stalls at random.
        // With both channels active the words must alternate 1,0,1,... from pointer 1.
        w0q.delete(); w1q.delete(); exp_q.delete(); got_q.delete();
        ws0 = a_ws;
        for (int i = 0; i < 300; i++) begin
            tick();
            check("t4_cap_onehot", 64'($onehot0(a_cap)), 64'(1));
            a_qr = (i < 250) ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (a_send && a_qr) got_q.push_back(8'(a_q));
            for (int c = 0; c < 2; c++) begin
                if (a_cap[c]) begin
                    a_rdy[c] = 1'b0;
                end else if (i < 250 && !a_rdy[c] && $urandom_range(0, 2) == 0) begin
                    w = $urandom;
                    a_data[c*32 +: 32] = w;
                    a_rdy[c] = 1'b1;
                    if (c == 0) w0q.push_back(w);
                    else        w1q.push_back(w);
                end
            end
        end
        nwords = int'(a_ws - ws0);
        ch = 1;
        for (int k = 0; k < nwords; k++) begin
            w = 32'd0;
            if (ch == 0 && w0q.size() > 0) w = w0q.pop_front();
            if (ch == 1 && w1q.size() > 0) w = w1q.pop_front();
            push_word(w, 32, 4, 1'b1, 1);
            ch = 1 - ch;
        end
        check("t4_min_words", 64'(nwords >= 10), 64'(1));
        compare_queues("t4_beat");

        // Reset in the middle of a word: outputs clear at once, restart from channel 0.
        a_qr = 1'b1;
        a_rdy = 2'b11;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            if (a_send) found = 1'b1;
        end
        check("t5_reached_send", 64'(found), 64'(1));
        repeat (3) tick();
        rst_n = 1'b0;
        #1;
        check("t5_rst_qspi_data", 64'(a_q), 64'(0));
        check("t5_rst_sending", 64'(a_send), 64'(0));
        check("t5_rst_capture", 64'(a_cap), 64'(0));
        check("t5_rst_words_sent", 64'(a_ws), 64'(0));
        check("t5_rst_state", 64'(a_st), 64'(0));
        w0 = $urandom;
        w1 = $urandom;
        a_data = {w1, w0};
        a_rdy = 2'b11;
        tick();
        rst_n = 1'b1;
        found = 1'b0;
        first_cap = '0; first_ws = '1; first_q = '0;
        for (int i = 0; i < 10 && !found; i++) begin
            tick();
            if (a_cap != 2'b00) begin
                found = 1'b1;
                first_cap = a_cap;
                first_ws = a_ws;
                first_q = a_q;
            end
        end
        a_rdy = 2'b00;
        check("t5_first_cap", 64'(first_cap), 64'(2'b01));
        check("t5_words_restart", 64'(first_ws), 64'(0));
        check("t5_first_beat", 64'(first_q), 64'(beat_of(w0, 0, 32, 4, 1'b1)));

        // Mask 1010 with all four channels ready: captures 1,3,1,3, then mask cleared.
        w3 = 16'($urandom);
        b_data = {w3, 16'($urandom), 16'hBEEF, 16'($urandom)};
        b_rdy = 4'hF;
        b_qr = 1'b1;
        act.delete(); exp_q.delete(); got_q.delete(); cap_log.delete();
        for (int c = 0; c < 4; c++) if (b_mask[c]) act.push_back(c);
        for (int k = 0; k < 4; k++)
            push_word(32'(b_data[act[k % act.size()]*16 +: 16]), 16, 8, 1'b1, 1);
        for (int i = 0; i < 40; i++) begin
            tick();
            check("t6_cap_onehot", 64'($onehot0(b_cap)), 64'(1));
            if (b_cap != 4'h0) begin
                cap_log.push_back($clog2(b_cap));
                if (cap_log.size() == 4) b_mask = 4'h0;
            end
            if (b_send && b_qr) got_q.push_back(b_q);
        end
        check("t6_cap_count", 64'(cap_log.size()), 64'(4));
        for (int k = 0; k < cap_log.size() && k < 4; k++)
            check("t6_cap_order", 64'(cap_log[k]), 64'(act[k % act.size()]));
        check("t6_first_beat_be", 64'(got_q.size() > 0 ? got_q[0] : 8'h00), 64'(8'hBE));
        compare_queues("t6_beat");
        busy = 1'b0;
        repeat (8) begin
            tick();
            if (b_send || b_st || b_cap != 4'h0) busy = 1'b1;
        end
        check("t6_mask_zero_idle", 64'(busy), 64'(0));
        check("t6_words_sent", 64'(b_ws), 64'(4));

        // Single lane, LSB first: 0xA5 leaves as 1,0,1,0,0,1,0,1.
        c_data = 8'hA5;
        c_rdy = 1'b1;
        c_qr = 1'b1;
        exp_q.delete(); got_q.delete();
        push_word(32'h000000A5, 8, 1, 1'b0, 1);
        for (int i = 0; i < 20; i++) begin
            tick();
            if (c_cap[0]) c_rdy = 1'b0;
            if (c_send && c_qr) got_q.push_back(8'(c_q));
        end
        compare_queues("t7_beat");
        check("t7_words_sent", 64'(c_ws), 64'(1));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
